apb_master: RTL and testbench
=============================

# apb_master

Single-channel APB requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns a read-data/error response. It sits between an internal initiator (test sequencer, DMA or CPU shim) and any APB completer in the design, including the memory-backed APB slave. It supports back-to-back transfers, wait states via PREADY, and an optional watchdog that aborts a hung transfer.

## Interface
- ADDR_WIDTH, 32, width of PADDR / cmd_addr (matches `addr_t`).
- DATA_WIDTH, 32, width of PWDATA / PRDATA (matches `data_t`).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort. Used only with `APB_MASTER_TIMEOUT_EN`. Legal range is ≥1.
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this edge when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_WIDTH  captured PRDATA for reads; 0 for writes and aborts.
- rsp_err  out  1  captured PSLVERR, or 1 on timeout abort.
- PSEL, PENABLE, PWRITE  out  1  APB controls.
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH  APB address and write data.
- PREADY, PSLVERR  in  1; PRDATA  in  DATA_WIDTH  APB completer returns.

## Operation
- The FSM uses `apb_state_t`: IDLE, SETUP, ACCESS.
- **IDLE:** PSEL=0, PENABLE=0. On cmd_valid && cmd_ready, the FSM latches write/addr/wdata into PWRITE/PADDR/PWDATA and moves to SETUP.
- **SETUP:** exactly one cycle with PSEL=1, PENABLE=0. Moves unconditionally to ACCESS.
- **ACCESS:** PSEL=1, PENABLE=1. PADDR/PWRITE/PWDATA are stable from SETUP through the end of ACCESS.
  - PREADY low: the FSM stays in ACCESS (wait state).
  - PREADY high: the transfer completes. rsp_rdata ← PWRITE ? 0 : PRDATA, rsp_err ← PSLVERR, and rsp_valid is set.
  - After completion, if a new command is accepted the same edge, the next state is SETUP (back-to-back, PSEL stays 1). Otherwise the next state is IDLE.
- cmd_ready = (state==IDLE || (state==ACCESS && PREADY)) && (!rsp_valid || rsp_ready). It is combinational on PREADY and rsp_ready.
- rsp_valid clears on rsp_valid && rsp_ready unless a completion on the same edge reloads it. Reload wins.
- At most one outstanding transfer. A command is never accepted while an unaccepted response is pending.
- Reset values: all outputs are 0 and state is IDLE. Asserting PRESETn low mid-transfer drops PSEL/PENABLE immediately, and the in-flight command produces no response.
- PADDR/PWDATA/PWRITE retain their last values in IDLE. They do not toggle without a command.

## Timing
- Zero-wait completer: command accepted at edge N gives SETUP in cycle N+1 and ACCESS in N+2. If PREADY=1 in N+2, rsp_valid is high from N+3.
- Registered-PREADY completer (the memory slave): PREADY arrives in the second ACCESS cycle, so rsp_valid is high at N+4.
- Each wait state adds one cycle.
- Back-to-back minimum is 2 APB cycles per transfer plus wait states. There is no IDLE gap.

## Configuration
- **`APB_MASTER_TIMEOUT_EN` defined:** a counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP and increments each ACCESS cycle with PREADY low.
  - When it reaches TIMEOUT_CYCLES while PREADY is still low, the transfer aborts: next state IDLE, PSEL=PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - A command is not accepted on the abort edge.
- **Not defined:** there is no counter, and ACCESS waits for PREADY indefinitely.

## Structure
- The shared package `apb_pkg` provides `apb_state_t`, `addr_t`, `data_t`, and a `APB_TIMEOUT_DEFAULT` constant (16).
- A single module with no sub-module. The timeout counter is small enough to stay inline under the macro.

## Test plan
- **Write then read, memory slave:** write 0x010 = 0xDEADBEEF, then read 0x010 → rsp_rdata=0xDEADBEEF, rsp_err=0. PADDR stays stable across SETUP/ACCESS.
- **Read of initialised memory:** read 0x005 → rsp_rdata=0x00000005. rsp_valid rises 4 cycles after accept.
- **Out-of-range:** read 0x7D0 (2000) → rsp_err=1, rsp_rdata=0.
- **Back-to-back:** cmd_valid held with rsp_ready=1 for 4 writes → PSEL never drops between transfers and 4 responses are returned. With rsp_ready=0, cmd_ready stays low after the first completion.
- **Timeout (`APB_MASTER_TIMEOUT_EN`, TIMEOUT_CYCLES=16), PREADY tied 0:**
  - rsp_err=1 after 16 ACCESS cycles, then PSEL=0.
  - With the macro undefined, the master stays in ACCESS for ≥100 cycles.
- **Reset mid-ACCESS:** pulse PRESETn low during a wait state → PSEL/PENABLE/rsp_valid go 0 asynchronously. After release, a new read to 0x003 returns 0x00000003.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB types and constants used by the requester and its completers.
package apb_pkg;

    localparam int APB_ADDR_W          = 32;
    localparam int APB_DATA_W          = 32;
    localparam int APB_TIMEOUT_DEFAULT = 16;

    typedef logic [APB_ADDR_W-1:0] addr_t;
    typedef logic [APB_DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_master.sv
// Single-channel APB requester: valid/ready command in, SETUP/ACCESS transfer out, rdata/err response back.
// Latency: accept -> SETUP -> ACCESS (+1 per wait state) -> response registered on the PREADY edge.
// Backpressure: no command accepted while a response is pending unless it is consumed that edge.
// Optional watchdog abort of hung transfers under APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,

    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    apb_state_t state;
    logic       complete;
    logic       accept;
    logic       abort;

    assign complete  = (state == ACCESS) && PREADY;
    assign cmd_ready = ((state == IDLE) || complete) && (!rsp_valid || rsp_ready);
    assign accept    = cmd_valid && cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Abort on the edge that would bring the wait count up to TIMEOUT_CYCLES.
    assign abort = (state == ACCESS) && !PREADY && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // Watchdog compiled out: the comparison is constant false and keeps the parameter referenced.
    assign abort = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= PWRITE ? '0 : PRDATA;
                        rsp_err   <= PSLVERR;
                        if (accept) begin
                            // Back-to-back: PSEL stays high straight into the next SETUP.
                            PWRITE  <= cmd_write;
                            PADDR   <= cmd_addr;
                            PWDATA  <= cmd_wdata;
                            PENABLE <= 1'b0;
                            state   <= SETUP;
                        end else begin
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (abort) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: behavioural APB memory completer plus a sparse-array reference model.
module tb_apb_master;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TO   = 16;
    localparam int MEMW = 1024;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic          PREADY, PSLVERR;
    logic [DW-1:0] PRDATA;

    int total = 0;
    int bad   = 0;

    // completer behaviour: 0 = registered-PREADY memory (+extra_waits), 1 = zero-wait, 2 = never ready
    int mode = 0;
    int extra_waits = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    // ---------------- behavioural memory completer ----------------
    logic [DW-1:0] smem    [MEMW];
    bit            smem_wr [MEMW];
    logic          pready_q;
    int            wait_left;
    logic          in_range;

    assign in_range = (PADDR < MEMW);
    assign PREADY   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : pready_q;
    assign PSLVERR  = PSEL && PENABLE && PREADY && !in_range;
    assign PRDATA   = (PSEL && PENABLE && PREADY && !PWRITE && in_range) ?
                      (smem_wr[PADDR[9:0]] ? smem[PADDR[9:0]] : {22'd0, PADDR[9:0]}) : '0;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pready_q  <= 1'b0;
            wait_left <= 0;
        end else if (PSEL && !PENABLE) begin
            pready_q  <= 1'b0;
            wait_left <= extra_waits;
        end else if (PSEL && PENABLE && !pready_q) begin
            if (wait_left == 0) pready_q <= 1'b1;
            else                wait_left <= wait_left - 1;
        end else begin
            pready_q <= 1'b0;
        end
    end

    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PREADY && PWRITE && in_range) begin
            smem[PADDR[9:0]]    <= PWDATA;
            smem_wr[PADDR[9:0]] <= 1'b1;
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [int];

    task automatic model(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output logic [DW-1:0] er, output logic ee);
        bit ok;
        ok = (addr < MEMW);
        ee = !ok;
        if (wr || !ok)                 er = '0;
        else if (ref_mem.exists(int'(addr))) er = ref_mem[int'(addr)];
        else                           er = addr;
        if (wr && ok) ref_mem[int'(addr)] = wdata;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int budget, output int lat, output bit got);
        int n;
        @(negedge PCLK);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge PCLK); #1; n++;
        end
        chk("cmd_accept", cmd_ready, 1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < budget) begin
            @(negedge PCLK); #1; lat++;
            if (lat == 1)       chk("setup_phase", {PSEL, PENABLE}, 2'b10);
            else if (!rsp_valid) chk("access_phase", {PSEL, PENABLE}, 2'b11);
            if (PSEL) begin
                chk("paddr_stable", PADDR, addr);
                chk("pwrite_stable", PWRITE, wr);
                if (wr) chk("pwdata_stable", PWDATA, wdata);
            end
        end
        got = rsp_valid;
        if (got) chk("psel_released", {PSEL, PENABLE}, 2'b00);
    endtask

    task automatic take(input int hold);
        repeat (hold) begin
            @(negedge PCLK); #1;
            chk("rsp_held", rsp_valid, 1);
            chk("no_accept_while_pending", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
    endtask

    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int hold);
        int lat;
        bit got;
        logic [DW-1:0] er;
        logic ee;
        model(wr, addr, wdata, er, ee);
        issue(wr, addr, wdata, 200, lat, got);
        chk("rsp_seen", got, 1);
        chk("latency", lat, (mode == 1) ? 3 : 4 + extra_waits);
        chk("rsp_rdata", rsp_rdata, er);
        chk("rsp_err", rsp_err, ee);
        take(hold);
    endtask

    task automatic pulse_reset();
        #2;
        PRESETn = 1'b0;
        #1;
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (5) begin
            @(negedge PCLK); #1;
            chk("no_rsp_after_reset", rsp_valid, 0);
            chk("idle_after_reset", PSEL, 0);
        end
    endtask

    task automatic b2b();
        int k, nrsp, drop;
        bit started;
        logic [AW-1:0] a [4];
        logic [DW-1:0] d [4];
        logic [DW-1:0] er;
        logic ee;
        for (int i = 0; i < 4; i++) begin
            a[i] = 40 + i;
            d[i] = $urandom;
        end
        k = 0; nrsp = 0; drop = 0; started = 0;
        @(negedge PCLK);
        cmd_write = 1'b1; cmd_addr = a[0]; cmd_wdata = d[0]; cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && nrsp < 4; cyc++) begin
            #1;
            if (rsp_valid) begin
                chk("b2b_err", rsp_err, 0);
                chk("b2b_rdata", rsp_rdata, 0);
                nrsp++;
            end
            if (PSEL) started = 1;
            else if (started && nrsp < 4) drop++;
            if (cmd_valid && cmd_ready) begin
                model(1'b1, a[k], d[k], er, ee);
                k++;
            end
            @(negedge PCLK);
            if (k < 4) begin
                cmd_addr = a[k]; cmd_wdata = d[k];
            end else begin
                cmd_valid = 1'b0;
            end
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk("b2b_accepted", k, 4);
        chk("b2b_responses", nrsp, 4);
        chk("b2b_psel_drops", drop, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit got;
        logic [DW-1:0] er;
        logic ee;
        bit wr;
        logic [AW-1:0] addr;

        #1;
        chk("reset_psel", PSEL, 0);
        chk("reset_penable", PENABLE, 0);
        chk("reset_pwrite", PWRITE, 0);
        chk("reset_paddr", PADDR, 0);
        chk("reset_pwdata", PWDATA, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;

        mode = 0; extra_waits = 0;
        xfer(1'b1, 32'h010, 32'hDEADBEEF, 0);
        xfer(1'b0, 32'h010, 32'h0, 2);
        xfer(1'b0, 32'h005, 32'h0, 0);
        xfer(1'b0, 32'h7D0, 32'h0, 1);

        mode = 1;
        xfer(1'b0, 32'h010, 32'h0, 0);
        xfer(1'b1, 32'h3FF, 32'h12345678, 0);
        xfer(1'b0, 32'h3FF, 32'h0, 0);

        // back-to-back with the memory completer
        mode = 0; extra_waits = 0;
        b2b();
        xfer(1'b0, 32'd43, 32'h0, 0);

        // completion with the consumer stalled: the next command must wait
        model(1'b0, 32'h006, 32'h0, er, ee);
        issue(1'b0, 32'h006, 32'h0, 50, lat, got);
        chk("stall_rsp_seen", got, 1);
        chk("stall_rdata", rsp_rdata, er);
        cmd_write = 1'b0; cmd_addr = 32'h007; cmd_valid = 1'b1;
        repeat (5) begin
            @(negedge PCLK); #1;
            chk("stall_cmd_ready", cmd_ready, 0);
            chk("stall_psel", PSEL, 0);
        end
        cmd_valid = 1'b0;
        take(0);

        // hung completer
        mode = 2;
`ifdef APB_MASTER_TIMEOUT_EN
        issue(1'b0, 32'h020, 32'h0, 40, lat, got);
        chk("timeout_rsp", got, 1);
        chk("timeout_latency", lat, TO + 2);
        chk("timeout_err", rsp_err, 1);
        chk("timeout_rdata", rsp_rdata, 0);
        take(0);
`else
        issue(1'b0, 32'h020, 32'h0, 100, lat, got);
        chk("no_timeout_rsp", got, 0);
        chk("no_timeout_access", {PSEL, PENABLE}, 2'b11);
        pulse_reset();
`endif
        mode = 0;

        // reset during a wait state
        extra_waits = 6;
        issue(1'b0, 32'h030, 32'h0, 4, lat, got);
        chk("midreset_in_flight", got, 0);
        pulse_reset();
        extra_waits = 0;
        xfer(1'b0, 32'h003, 32'h0, 0);
        chk("read_0x003", rsp_rdata, 32'h3);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            mode        = $urandom_range(0, 1);
            extra_waits = $urandom_range(0, 3);
            wr          = 1'($urandom_range(0, 1));
            addr        = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1024, 4095))
                                                      : 32'($urandom_range(8, 71));
            xfer(wr, addr, $urandom, $urandom_range(0, 3));
        end

        repeat (3) @(negedge PCLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
